// File: rtl/ahb3lite_dma_pkg.sv
// ahb3lite_dma_pkg
// Shared constants and types for the single-channel AHB3-Lite DMA engine:
// AHB transfer-type encodings, register word offsets (haddr[4:2]) and the
// master-side state enumeration.
package ahb3lite_dma_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] REG_SRC    = 3'd0;
   localparam logic [2:0] REG_DST    = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D
   } dma_state_t;

endpackage

// File: rtl/ahb3lite_dma_if.sv
// ahb3lite_dma_if
// One AHB3-Lite port bundle. The DMA uses one instance through the slave
// modport (CPU register access) and another through the master modport
// (its own bus traffic).
//   master : drives address/control/write data, receives hrdata/hready/hresp
//   slave  : receives hsel/address/control/write data/hready,
//            drives hrdata/hreadyout/hresp
interface ahb3lite_dma_if #(
   parameter int g_haddr_size = 32,
   parameter int g_hdata_size = 32
);
   logic                    hsel;
   logic [g_haddr_size-1:0] haddr;
   logic [g_hdata_size-1:0] hwdata;
   logic [g_hdata_size-1:0] hrdata;
   logic                    hwrite;
   logic [2:0]              hsize;
   logic [2:0]              hburst;
   logic [3:0]              hprot;
   logic [1:0]              htrans;
   logic                    hmastlock;
   logic                    hready;
   logic                    hreadyout;
   logic                    hresp;

   modport master (
      output haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hready,
      output hrdata, hreadyout, hresp
   );
endinterface

// File: rtl/ahb3lite_dma_regs.sv
// ahb3lite_dma_regs
// CPU-visible register file of the DMA (SRC, DST, LEN, CTRL, STATUS).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   s_ahb             AHB slave port (always ready, never errors)
//   busy_i            transfer in progress (from the master FSM)
//   set_done_i        completion or abort: set DONE
//   set_err_i         error response seen: set ERR
//   start_o           one-cycle pulse launching a non-empty copy
//   src_o/dst_o/len_o programmed transfer parameters
//   irq_o             registered DONE & IRQ_EN
module ahb3lite_dma_regs
   import ahb3lite_dma_pkg::*;
#(
   parameter int g_haddr_size = 32,
   parameter int g_hdata_size = 32,
   parameter int g_len_width  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   ahb3lite_dma_if.slave           s_ahb,
   input  logic                    busy_i,
   input  logic                    set_done_i,
   input  logic                    set_err_i,
   output logic                    start_o,
   output logic [g_haddr_size-1:0] src_o,
   output logic [g_haddr_size-1:0] dst_o,
   output logic [g_len_width-1:0]  len_o,
   output logic                    irq_o
);

   logic [2:0]              addr_q;
   logic                    wr_q;
   logic [g_haddr_size-1:0] src_q, src_d;
   logic [g_haddr_size-1:0] dst_q, dst_d;
   logic [g_len_width-1:0]  len_q, len_d;
   logic                    irq_en_q, irq_en_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    irq_q;
   logic [g_hdata_size-1:0] rdata;
   logic                    unused_ok;

   assign unused_ok = ^{s_ahb.hsize, s_ahb.hburst, s_ahb.hprot, s_ahb.htrans[0],
                        s_ahb.haddr[g_haddr_size-1:5], s_ahb.haddr[1:0]};

   assign s_ahb.hreadyout = 1'b1;
   assign s_ahb.hresp     = 1'b0;
   assign s_ahb.hrdata    = rdata;
   assign src_o           = src_q;
   assign dst_o           = dst_q;
   assign len_o           = len_q;
   assign irq_o           = irq_q;

   // Address phase: remember offset and direction; a write commits in the
   // following (data) cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
         wr_q   <= 1'b0;
      end else if (s_ahb.hready) begin
         wr_q <= s_ahb.hsel & s_ahb.htrans[1] & s_ahb.hwrite;
         if (s_ahb.hsel & s_ahb.htrans[1])
            addr_q <= s_ahb.haddr[4:2];
      end
   end

   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      start_o  = 1'b0;
      if (wr_q) begin
         case (addr_q)
            REG_SRC: if (!busy_i) src_d = g_haddr_size'(s_ahb.hwdata) & ~g_haddr_size'(3);
            REG_DST: if (!busy_i) dst_d = g_haddr_size'(s_ahb.hwdata) & ~g_haddr_size'(3);
            REG_LEN: if (!busy_i) len_d = s_ahb.hwdata[g_len_width-1:0];
            REG_CTRL: begin
               irq_en_d = s_ahb.hwdata[1];
               if (s_ahb.hwdata[0] && !busy_i) begin
                  err_d = 1'b0;
                  // An empty copy completes at once without touching the bus.
                  if (len_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     done_d  = 1'b0;
                     start_o = 1'b1;
                  end
               end
            end
            REG_STATUS: if (s_ahb.hwdata[1]) done_d = 1'b0;
            default: ;
         endcase
      end
      // Hardware set has priority over a simultaneous write-1-to-clear.
      if (set_done_i) done_d = 1'b1;
      if (set_err_i)  err_d  = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         irq_q    <= done_d & irq_en_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr_q)
         REG_SRC:    rdata = g_hdata_size'(src_q);
         REG_DST:    rdata = g_hdata_size'(dst_q);
         REG_LEN:    rdata = g_hdata_size'(len_q);
         REG_CTRL:   rdata = g_hdata_size'({irq_en_q, 1'b0});
         REG_STATUS: rdata = g_hdata_size'({err_q, done_q, busy_i});
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/ahb3lite_dma.sv
// ahb3lite_dma
// Single-channel word-copy DMA: reads one word from SRC, writes it to DST,
// advances both by 4 and repeats LEN times (4 cycles/word at zero wait).
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   s_ahb         AHB slave port to the register file
//   m_ahb         AHB master port used for the copy traffic
//   irq_o         completion interrupt (DONE & IRQ_EN)
module ahb3lite_dma
   import ahb3lite_dma_pkg::*;
#(
   parameter int g_haddr_size = 32,
   parameter int g_hdata_size = 32,
   parameter int g_len_width  = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   ahb3lite_dma_if.slave  s_ahb,
   ahb3lite_dma_if.master m_ahb,
   output logic           irq_o
);

   dma_state_t              state_q, state_d;
   logic [g_haddr_size-1:0] src_q, src_d, dst_q, dst_d;
   logic [g_len_width-1:0]  cnt_q, cnt_d;
   logic [g_hdata_size-1:0] buf_q, buf_d;
   logic                    start, set_done, set_err;
   logic [g_haddr_size-1:0] reg_src, reg_dst;
   logic [g_len_width-1:0]  reg_len;

   ahb3lite_dma_regs #(
      .g_haddr_size(g_haddr_size),
      .g_hdata_size(g_hdata_size),
      .g_len_width (g_len_width)
   ) u_regs (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .s_ahb     (s_ahb),
      .busy_i    (state_q != ST_IDLE),
      .set_done_i(set_done),
      .set_err_i (set_err),
      .start_o   (start),
      .src_o     (reg_src),
      .dst_o     (reg_dst),
      .len_o     (reg_len),
      .irq_o     (irq_o)
   );

   assign m_ahb.hsize     = 3'b010;
   assign m_ahb.hburst    = 3'b000;
   assign m_ahb.hprot     = 4'b0011;
   assign m_ahb.hmastlock = 1'b0;
   assign m_ahb.hwdata    = buf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Outputs depend on state only, so they stay put while hready holds a state.
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      dst_d         = dst_q;
      cnt_d         = cnt_q;
      buf_d         = buf_q;
      set_done      = 1'b0;
      set_err       = 1'b0;
      m_ahb.htrans  = HTRANS_IDLE;
      m_ahb.haddr   = src_q;
      m_ahb.hwrite  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d   = reg_src;
               dst_d   = reg_dst;
               cnt_d   = reg_len;
               state_d = ST_RD_A;
            end
         end
         ST_RD_A: begin
            m_ahb.htrans = HTRANS_NONSEQ;
            if (m_ahb.hready) state_d = ST_RD_D;
         end
         ST_RD_D: begin
            if (m_ahb.hresp) begin
               state_d  = ST_IDLE;
               set_done = 1'b1;
               set_err  = 1'b1;
            end else if (m_ahb.hready) begin
               buf_d   = m_ahb.hrdata;
               state_d = ST_WR_A;
            end
         end
         ST_WR_A: begin
            m_ahb.htrans = HTRANS_NONSEQ;
            m_ahb.haddr  = dst_q;
            m_ahb.hwrite = 1'b1;
            if (m_ahb.hready) state_d = ST_WR_D;
         end
         ST_WR_D: begin
            m_ahb.haddr = dst_q;
            if (m_ahb.hresp) begin
               state_d  = ST_IDLE;
               set_done = 1'b1;
               set_err  = 1'b1;
            end else if (m_ahb.hready) begin
               src_d = src_q + g_haddr_size'(4);
               dst_d = dst_q + g_haddr_size'(4);
               cnt_d = cnt_q - g_len_width'(1);
               if (cnt_q == g_len_width'(1)) begin
                  state_d  = ST_IDLE;
                  set_done = 1'b1;
               end else begin
                  state_d = ST_RD_A;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ahb3lite_dma.sv
module tb_ahb3lite_dma;
   import ahb3lite_dma_pkg::*;

   localparam logic [7:0] O_SRC = 8'h00, O_DST = 8'h04, O_LEN = 8'h08,
                          O_CTRL = 8'h0C, O_STAT = 8'h10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;

   always #5 clk = ~clk;

   ahb3lite_dma_if #(.g_haddr_size(32), .g_hdata_size(32)) s_if ();
   ahb3lite_dma_if #(.g_haddr_size(32), .g_hdata_size(32)) m_if ();

   ahb3lite_dma #(.g_haddr_size(32), .g_hdata_size(32), .g_len_width(16)) dut (
      .clk_i(clk), .rst_i(rst), .s_ahb(s_if), .m_ahb(m_if), .irq_o(irq)
   );

   int n_chk = 0;
   int n_err = 0;

   // behavioural memory + bus responder state
   bit [31:0] mem [bit [31:0]];
   bit [31:0] exp_q[$];
   bit [31:0] rd_addrs[$];
   int        cyc_n = 0;
   bit        dp_v = 0, dp_w = 0;
   bit [31:0] dp_a;
   int        dp_wait = 0, ws = 0;
   int        rd_cnt, wr_cnt, nseq_cnt, err_rd_n = 0, first_ns, last_wr;
   bit        hold_chk = 0;
   logic [31:0] hold_addr;
   logic [1:0]  hold_trans;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One bus cycle: at the falling edge decide this cycle's response and
   // account for what the coming rising edge completes/accepts.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (hold_chk) begin
         check_eq("stall_haddr", m_if.haddr, hold_addr);
         check_eq("stall_htrans", {30'b0, m_if.htrans}, {30'b0, hold_trans});
      end
      m_if.hresp = 1'b0;
      if (dp_v && dp_wait > 0) begin
         m_if.hready = 1'b0;
         dp_wait--;
         hold_chk   = 1;
         hold_addr  = m_if.haddr;
         hold_trans = m_if.htrans;
      end else begin
         hold_chk    = 0;
         m_if.hready = 1'b1;
         if (dp_v) begin
            if (dp_w) begin
               mem[dp_a] = m_if.hwdata;
               wr_cnt++;
               last_wr = cyc_n;
            end else begin
               rd_cnt++;
               if (rd_cnt == err_rd_n) m_if.hresp = 1'b1;
               else m_if.hrdata = mem[dp_a];
            end
         end
         dp_v = 0;
         if (m_if.htrans == HTRANS_NONSEQ) begin
            dp_v = 1; dp_a = m_if.haddr; dp_w = m_if.hwrite; dp_wait = ws;
            nseq_cnt++;
            if (first_ns < 0) first_ns = cyc_n;
            if (!dp_w) rd_addrs.push_back(dp_a);
         end
      end
   endtask

   task automatic reg_write(input logic [7:0] off, input logic [31:0] d);
      cyc();
      s_if.hsel = 1'b1; s_if.haddr = 32'h4000_0400 | {24'b0, off};
      s_if.hwrite = 1'b1; s_if.htrans = HTRANS_NONSEQ;
      cyc();
      s_if.hsel = 1'b0; s_if.htrans = HTRANS_IDLE; s_if.hwrite = 1'b0;
      s_if.hwdata = d;
   endtask

   task automatic reg_read(input logic [7:0] off, output logic [31:0] d);
      cyc();
      s_if.hsel = 1'b1; s_if.haddr = 32'h4000_0400 | {24'b0, off};
      s_if.hwrite = 1'b0; s_if.htrans = HTRANS_NONSEQ;
      cyc();
      s_if.hsel = 1'b0; s_if.htrans = HTRANS_IDLE;
      d = s_if.hrdata;
   endtask

   task automatic wait_idle();
      logic [31:0] st;
      st = 32'h1;
      for (int i = 0; i < 300 && st[0]; i++) reg_read(O_STAT, st);
      check_eq("busy_clears", {31'b0, st[0]}, 32'h0);
   endtask

   task automatic prep(input bit [31:0] src, input bit [31:0] dst, input int len, input int wsv);
      bit [31:0] w;
      exp_q.delete(); rd_addrs.delete();
      rd_cnt = 0; wr_cnt = 0; nseq_cnt = 0; first_ns = -1; last_wr = 0;
      ws = wsv;
      for (int i = 0; i < len; i++) begin
         w = $urandom;
         mem[src + 4 * i] = w;
         exp_q.push_back(w);
         mem[dst + 4 * i] = ~w;
      end
      reg_write(O_SRC, src);
      reg_write(O_DST, dst);
      reg_write(O_LEN, len);
   endtask

   task automatic verify(input bit [31:0] src, input bit [31:0] dst, input int len);
      for (int i = 0; i < len; i++) begin
         check_eq("dst_word", mem[dst + 4 * i], exp_q[i]);
         check_eq("rd_addr", rd_addrs[i], src + 4 * i);
      end
      check_eq("n_reads", rd_cnt, len);
      check_eq("n_writes", wr_cnt, len);
      check_eq("cycles", last_wr - first_ns + 1, len * (4 + 2 * ws));
   endtask

   task automatic run_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                           input int wsv, input bit ien);
      prep(src, dst, len, wsv);
      reg_write(O_CTRL, {30'b0, ien, 1'b1});
      wait_idle();
      verify(src, dst, len);
   endtask

   initial begin
      logic [31:0] r;
      bit [31:0] s, d;
      int l, w;
      s_if.hsel = 0; s_if.haddr = 0; s_if.hwdata = 0; s_if.hwrite = 0;
      s_if.hsize = 3'b010; s_if.hburst = 0; s_if.hprot = 4'b0011;
      s_if.htrans = HTRANS_IDLE; s_if.hready = 1'b1; s_if.hmastlock = 1'b0;
      m_if.hsel = 0; m_if.hready = 1'b1; m_if.hresp = 1'b0; m_if.hrdata = 0;
      m_if.hreadyout = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      check_eq("rst_irq", {31'b0, irq}, 0);
      check_eq("rst_htrans", {30'b0, m_if.htrans}, {30'b0, HTRANS_IDLE});
      reg_read(O_SRC, r);  check_eq("rst_src", r, 0);
      reg_read(O_DST, r);  check_eq("rst_dst", r, 0);
      reg_read(O_LEN, r);  check_eq("rst_len", r, 0);
      reg_read(O_CTRL, r); check_eq("rst_ctrl", r, 0);
      reg_read(O_STAT, r); check_eq("rst_status", r, 0);
      reg_read(8'h14, r);  check_eq("unmapped", r, 0);
      reg_write(O_SRC, 32'h1234_5677); reg_read(O_SRC, r); check_eq("src_align", r, 32'h1234_5674);
      reg_write(O_CTRL, 32'h2); reg_read(O_CTRL, r); check_eq("ctrl_rd", r, 32'h2);
      reg_write(O_CTRL, 32'h0);

      // zero-wait copy with interrupt
      run_copy(32'h2000_0000, 32'h2000_0100, 4, 0, 1'b1);
      reg_read(O_STAT, r); check_eq("copy_status", r, 32'h2);
      check_eq("irq_set", {31'b0, irq}, 1);
      reg_write(O_STAT, 32'h2); cyc();
      check_eq("irq_clr", {31'b0, irq}, 0);
      reg_read(O_STAT, r); check_eq("done_w1c", r, 0);

      // two wait states per data phase
      run_copy(32'h2000_0000, 32'h2000_0100, 4, 2, 1'b0);
      reg_read(O_STAT, r); check_eq("ws_status", r, 32'h2);
      check_eq("ws_irq_off", {31'b0, irq}, 0);
      reg_write(O_STAT, 32'h2);

      // empty copy
      prep(32'h2000_0000, 32'h2000_0100, 0, 0);
      reg_write(O_CTRL, 32'h1);
      reg_read(O_STAT, r); check_eq("len0_status", r, 32'h2);
      repeat (8) cyc();
      check_eq("len0_no_nseq", nseq_cnt, 0);

      // error response on the second read
      prep(32'h2000_0000, 32'h2000_0300, 4, 0);
      err_rd_n = 2;
      reg_write(O_CTRL, 32'h1);
      wait_idle();
      repeat (8) cyc();
      err_rd_n = 0;
      reg_read(O_STAT, r); check_eq("err_status", r, 32'h6);
      check_eq("err_writes", wr_cnt, 1);
      check_eq("err_reads", rd_cnt, 2);
      check_eq("err_nseq", nseq_cnt, 3);

      // register writes and START ignored while busy
      prep(32'h2000_0040, 32'h2000_0400, 4, 0);
      reg_write(O_CTRL, 32'h1);
      reg_write(O_LEN, 32'd9);
      reg_write(O_CTRL, 32'h1);
      reg_read(O_STAT, r); check_eq("busy_bit", {31'b0, r[0]}, 1);
      reg_read(O_LEN, r);  check_eq("len_locked", r, 4);
      wait_idle();
      verify(32'h2000_0040, 32'h2000_0400, 4);
      reg_read(O_STAT, r); check_eq("err_cleared", r, 32'h2);

      // address wrap
      run_copy(32'hFFFF_FFFC, 32'h2000_0200, 2, 0, 1'b0);
      check_eq("wrap_rd2", rd_addrs[1], 32'h0);

      // randomized copies
      for (int k = 0; k < 4; k++) begin
         l = $urandom_range(1, 6);
         w = $urandom_range(0, 2);
         s = 32'h2000_0000 + 4 * $urandom_range(0, 63);
         d = 32'h2000_1000 + 4 * $urandom_range(0, 63);
         run_copy(s, d, l, w, 1'($urandom_range(0, 1)));
      end

      // reset in the middle of a copy
      prep(32'h2000_0000, 32'h2000_0800, 8, 0);
      reg_write(O_CTRL, 32'h3);
      repeat (6) cyc();
      rst = 1'b1;
      #1;
      check_eq("rst_mid_htrans", {30'b0, m_if.htrans}, {30'b0, HTRANS_IDLE});
      check_eq("rst_mid_irq", {31'b0, irq}, 0);
      dp_v = 0; hold_chk = 0;
      repeat (2) cyc();
      rst = 1'b0;
      reg_read(O_STAT, r); check_eq("rst_mid_status", r, 0);
      reg_read(O_LEN, r);  check_eq("rst_mid_len", r, 0);
      nseq_cnt = 0;
      repeat (6) cyc();
      check_eq("rst_mid_quiet", nseq_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
